// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants for the LFSR core.
// Tap masks are for fb = ^(q & TAPS), q_next = {q[W-2:0], fb}.
package lfsr_pkg;

    localparam logic [2:0] LFSR_TAPS_W3 = 3'b101;
    localparam logic [3:0] LFSR_TAPS_W4 = 4'b1001;
    localparam logic [4:0] LFSR_TAPS_W5 = 5'b10010;
    localparam logic [5:0] LFSR_TAPS_W6 = 6'b100001;
    localparam logic [6:0] LFSR_TAPS_W7 = 7'b1000001;
    localparam logic [7:0] LFSR_TAPS_W8 = 8'b10001110;

    localparam int         LFSR_DEFAULT_WIDTH = 4;
    localparam logic [3:0] LFSR_DEFAULT_SEED  = 4'b0001;

endpackage

// File: rtl/lfsr_core_if.sv
// lfsr_core_if: control and status bundle of the LFSR core.
// master drives en/load/seed, slave (the core) drives state and pulses.
interface lfsr_core_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic [WIDTH-1:0] step_cnt;
    logic             period_done;
    logic             lockup;

    modport master (
        output en, load, seed,
        input  q, serial_out, step_cnt, period_done, lockup
    );

    modport slave (
        input  en, load, seed,
        output q, serial_out, step_cnt, period_done, lockup
    );

endinterface

// File: rtl/lfsr_state_reg.sv
// lfsr_state_reg: WIDTH-bit register, async active-high reset to INIT,
// synchronous load of d when ld is high, otherwise holds.
module lfsr_state_reg #(
    parameter int             WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // state flop: reset value, else optional load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= INIT;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR with seed load, step enable and period tracking.
// Define LFSR_LOCKUP_GUARD_EN to recover from the all-zero state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = LFSR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS_W4),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input logic        clk,
    input logic        rst,
    lfsr_core_if.slave bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] seed_d;
    logic [WIDTH-1:0] cnt;
    logic             fb;
    logic             step;
    logic             zero_step;
    logic             match;
    logic             pd;
    logic             lk;

    assign fb     = ^(q & TAPS);
    assign q_next = {q[WIDTH-2:0], fb};
    assign step   = bus.en & ~bus.load;

`ifdef LFSR_LOCKUP_GUARD_EN
    assign zero_step = step & (q == '0);
`else
    assign zero_step = 1'b0;
`endif

    assign match  = step & ~zero_step & (q_next == seed_reg);

    assign q_d    = bus.load  ? bus.seed   :
                    zero_step ? RESET_SEED : q_next;
    assign seed_d = bus.load  ? bus.seed   : RESET_SEED;

    lfsr_state_reg #(
        .WIDTH (WIDTH),
        .INIT  (RESET_SEED)
    ) u_q (
        .clk (clk),
        .rst (rst),
        .ld  (bus.load | step),
        .d   (q_d),
        .q   (q)
    );

    lfsr_state_reg #(
        .WIDTH (WIDTH),
        .INIT  (RESET_SEED)
    ) u_seed (
        .clk (clk),
        .rst (rst),
        .ld  (bus.load | zero_step),
        .d   (seed_d),
        .q   (seed_reg)
    );

    // step counter and one-cycle period/lockup pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            pd  <= 1'b0;
            lk  <= 1'b0;
        end else if (bus.load) begin
            cnt <= '0;
            pd  <= 1'b0;
            lk  <= 1'b0;
        end else if (step) begin
            if (zero_step) begin
                cnt <= '0;
                pd  <= 1'b0;
                lk  <= 1'b1;
            end else if (match) begin
                cnt <= '0;
                pd  <= 1'b1;
                lk  <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                pd  <= 1'b0;
                lk  <= 1'b0;
            end
        end else begin
            pd <= 1'b0;
            lk <= 1'b0;
        end
    end

    assign bus.q           = q;
    assign bus.serial_out  = q[WIDTH-1];
    assign bus.step_cnt    = cnt;
    assign bus.period_done = pd;
    assign bus.lockup      = lk;

endmodule

// File: tb/tb_lfsr_core.sv
// tb_lfsr_core: directed checks of lfsr_core at WIDTH=4, TAPS=1001.
// Define LFSR_LOCKUP_GUARD_EN to check the guarded build.
module tb_lfsr_core;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    lfsr_core_if #(.WIDTH(4)) bus ();

    lfsr_core #(
        .WIDTH      (4),
        .TAPS       (4'b1001),
        .RESET_SEED (4'b0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] q,
                       input logic [3:0] c, input logic pd,
                       input logic lk);
        vecs++;
        if (bus.q !== q) begin
            errs++;
            $display("FAIL %s q: got %b want %b", nm, bus.q, q);
        end
        if (bus.step_cnt !== c) begin
            errs++;
            $display("FAIL %s step_cnt: got %0d want %0d", nm,
                     bus.step_cnt, c);
        end
        if (bus.period_done !== pd) begin
            errs++;
            $display("FAIL %s period_done: got %b want %b", nm,
                     bus.period_done, pd);
        end
        if (bus.lockup !== lk) begin
            errs++;
            $display("FAIL %s lockup: got %b want %b", nm,
                     bus.lockup, lk);
        end
        if (bus.serial_out !== q[3]) begin
            errs++;
            $display("FAIL %s serial_out: got %b want %b", nm,
                     bus.serial_out, q[3]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.seed = 4'b0000;
        do_reset();
        chk("reset", 4'b0001, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_hold", 4'b0001, 4'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_period();
        logic [3:0] exp_q [15];
        exp_q = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
                  4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
                  4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 14)
                chk("period_end", exp_q[i], 4'd0, 1'b1, 1'b0);
            else
                chk("period_step", exp_q[i], 4'(i + 1), 1'b0, 1'b0);
        end
        bus.en = 1'b0;
        tick();
        chk("period_drop", 4'b0001, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_load_priority();
        bus.en   = 1'b1;
        bus.load = 1'b1;
        bus.seed = 4'b1010;
        tick();
        chk("load_prio", 4'b1010, 4'd0, 1'b0, 1'b0);
        bus.load = 1'b0;
        tick();
        chk("load_step", 4'b0101, 4'd1, 1'b0, 1'b0);
        bus.en = 1'b0;
        tick();
        chk("load_hold", 4'b0101, 4'd1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_seed();
        bus.load = 1'b1;
        bus.seed = 4'b0000;
        tick();
        chk("zero_load", 4'b0000, 4'd0, 1'b0, 1'b0);
        bus.load = 1'b0;
        bus.en   = 1'b1;
`ifdef LFSR_LOCKUP_GUARD_EN
        tick();
        chk("zero_recover", 4'b0001, 4'd0, 1'b0, 1'b1);
        tick();
        chk("zero_after", 4'b0011, 4'd1, 1'b0, 1'b0);
        tick();
        chk("zero_after2", 4'b0111, 4'd2, 1'b0, 1'b0);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zero_stuck", 4'b0000, 4'd0, 1'b1, 1'b0);
        end
`endif
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++)
            tick();
        chk("mid_run", 4'b1101, 4'd5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 4'b0001, 4'd0, 1'b0, 1'b0);
        tick();
        chk("rst_held", 4'b0001, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_resume", 4'b0011, 4'd1, 1'b0, 1'b0);
        bus.en = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic [3:0] exp_q [4];
        logic [3:0] exp_c [4];
        exp_q = '{4'b0111, 4'b0111, 4'b1111, 4'b1111};
        exp_c = '{4'd2, 4'd2, 4'd3, 4'd3};
        for (int i = 0; i < 4; i++) begin
            bus.en = (i % 2 == 0);
            tick();
            chk("en_toggle", exp_q[i], exp_c[i], 1'b0, 1'b0);
        end
        bus.en = 1'b0;
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.seed = 4'b0000;
        test_reset();
        test_period();
        test_load_priority();
        test_zero_seed();
        test_async_reset();
        test_en_toggle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
